// File: rtl/sub_shift_stage.sv
// AES ShiftRows + SubBytes stage. ShiftRows is applied when a block is accepted.
// SubBytes then runs over 16/LANES cycles through LANES shared S-box instances.

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // The inverse is computed as a^254, which also gives 0 for an input of 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// state | meaning
// IDLE  | waiting for a block, in_ready high
// SUB   | substituting LANES bytes of the working register per cycle
// DONE  | result presented, waiting for out_ready
module sub_shift_stage #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int N     = 16 / LANES;
    localparam int CNT_W = $clog2(N) + 1;

    generate
        if (LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("sub_shift_stage: LANES must be 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [127:0]       r_work;
    logic [127:0]       r_out_data;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [6:0]         w_base;
    logic [7:0]         w_sb_in  [LANES];
    logic [7:0]         w_sb_out [LANES];
    logic [127:0]       w_work_next;

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[32*c+31-8*r -: 8] = s[32*((c+r)%4)+31-8*r -: 8];
            end
        end
        return t;
    endfunction

    assign w_base = 7'(int'(r_cnt) * LANES * 8);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign w_sb_in[g] = r_work[w_base + 7'(8*g) +: 8];
            aes_sbox u_sbox (
                .i_byte (w_sb_in[g]),
                .o_byte (w_sb_out[g])
            );
        end
    endgenerate

    always_comb begin
        w_work_next = r_work;
        for (int i = 0; i < LANES; i++) begin
            w_work_next[w_base + 7'(8*i) +: 8] = w_sb_out[i];
        end
    end

    // out_data has its own register so a new accept cannot disturb the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_work     <= shift_rows(in_data);
                        r_cnt      <= '0;
                        r_state    <= SUB;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SUB: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_out_data  <= w_work_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
endmodule

// File: tb/tb_sub_shift_stage.sv
// Directed bench for sub_shift_stage; LANES=4, 8 and 16 instances share one stimulus.

module tb_sub_shift_stage;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic         in_ready4, out_valid4, busy4;
    logic         in_ready8, out_valid8, busy8;
    logic         in_ready16, out_valid16, busy16;
    logic [127:0] out_data4, out_data8, out_data16;

    logic         ov [3];
    logic         ir [3];
    logic         bz [3];
    logic [127:0] od [3];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl [4];

    localparam logic [127:0] ALL_63 = {16{8'h63}};
    localparam logic [127:0] ALL_16 = {16{8'h16}};
    localparam logic [127:0] ALL_FF = {16{8'hff}};

    sub_shift_stage #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4));
    sub_shift_stage #(.LANES(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .busy(busy8));
    sub_shift_stage #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .busy(busy16));

    assign ov[0] = out_valid4;  assign ov[1] = out_valid8;  assign ov[2] = out_valid16;
    assign ir[0] = in_ready4;   assign ir[1] = in_ready8;   assign ir[2] = in_ready16;
    assign bz[0] = busy4;       assign bz[1] = busy8;       assign bz[2] = busy16;
    assign od[0] = out_data4;   assign od[1] = out_data8;   assign od[2] = out_data16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Accept one block on the next edge, then check all three lanes for 5 cycles.
    task automatic run_vec(input int idx);
        int lat [3];
        lat[0] = 4; lat[1] = 2; lat[2] = 1;
        in_valid  = 1'b1;
        in_data   = tbl[idx].din;
        out_ready = 1'b1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("v%0d_l%0d_ready_pre", idx, d), 128'(ir[d]), 128'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("v%0d_l%0d_ready_k0", idx, d), 128'(ir[d]), 128'(1'b0));
            chk($sformatf("v%0d_l%0d_busy_k0", idx, d), 128'(bz[d]), 128'(1'b1));
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("v%0d_l%0d_valid_k%0d", idx, d, k), 128'(ov[d]), 128'(k == lat[d]));
                chk($sformatf("v%0d_l%0d_ready_k%0d", idx, d, k), 128'(ir[d]), 128'(k > lat[d]));
                if (k == lat[d])
                    chk($sformatf("v%0d_l%0d_data", idx, d), od[d], tbl[idx].dout);
            end
        end
    endtask

    initial begin
        tbl[0].din  = '0;
        tbl[0].dout = ALL_63;
        tbl[1].din  = 128'h00000000_00000000_00000000_00010000;
        tbl[1].dout = 128'h637c6363_63636363_63636363_63636363;
        tbl[2].din  = 128'he9f84808_9ac68d2a_a0f4e22b_193de3be;
        tbl[2].dout = 128'h1e2798e5_b84111f1_e0b452ae_d4bf5d30;
        tbl[3].din  = {16{8'h53}};
        tbl[3].dout = {16{8'hed}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_ready", 128'(in_ready4), 128'(1'b1));
        chk("rst_valid", 128'(out_valid4), 128'(1'b0));
        chk("rst_busy", 128'(busy4), 128'(1'b0));
        chk("rst_data", out_data4, 128'h0);

        // The first vector is presented while reset releases, so it must be taken on the next edge.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) run_vec(i);

        // Backpressure: result must hold while out_ready stays low.
        in_valid  = 1'b1;
        in_data   = ALL_FF;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid_k%0d", k), 128'(out_valid4), 128'(k >= 4));
            chk($sformatf("bp_ready_k%0d", k), 128'(in_ready4), 128'(1'b0));
            if (k >= 4) chk($sformatf("bp_data_k%0d", k), out_data4, ALL_16);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 128'(out_valid4), 128'(1'b0));
        chk("bp_release_ready", 128'(in_ready4), 128'(1'b1));
        chk("bp_release_data", out_data4, ALL_16);
        chk("bp_l8_data", out_data8, ALL_16);
        chk("bp_l16_data", out_data16, ALL_16);

        // Asynchronous reset after two SUB edges on the LANES=4 instance.
        in_valid = 1'b1;
        in_data  = tbl[2].din;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy4), 128'(1'b0));
        chk("arst_valid", 128'(out_valid4), 128'(1'b0));
        chk("arst_data", out_data4, 128'h0);
        chk("arst_ready", 128'(in_ready4), 128'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("arst_no_valid_%0d", k), 128'(out_valid4), 128'(1'b0));
        end
        run_vec(3);

        // A second block offered during SUB must wait until the stage is idle again.
        in_valid  = 1'b1;
        in_data   = tbl[2].din;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_data = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ovl_valid_k%0d", k), 128'(out_valid4), 128'(k == 4 || k == 10));
            if (k == 4) chk("ovl_first_data", out_data4, tbl[2].dout);
            if (k == 5) chk("ovl_ready_k5", 128'(in_ready4), 128'(1'b1));
            if (k == 6) chk("ovl_busy_k6", 128'(busy4), 128'(1'b1));
            if (k == 10) chk("ovl_second_data", out_data4, ALL_63);
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("end_l%0d_idle", d), 128'(bz[d]), 128'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
